// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 8-bit accumulator ISA: walks each instruction
// through DECODE/EXEC/MEM/WB with instruction and data-memory handshakes, traps and a retire counter.
module multicycle_control #(
  parameter int OPW         = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero_flag,
  input  logic            mem_ack,
  input  logic            err_clr,
  output logic            mem_req,
  output logic            mem_we,
  output logic            reg_we,
  output logic            two_reg_en,
  output logic [2:0]      alu_op,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic [CNTW-1:0] retired,
  output logic [2:0]      dbgState
);

  // Handshakes: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // a memory request completes on an edge where mem_req && mem_ack (mem_ack is ignored otherwise).

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } stateT;

  stateT            state, nextState;
  logic [OPW-1:0]   opLat;
  logic             zfLat;
  logic [CW-1:0]    memCnt;
  logic [1:0]       errCause;
  logic             swDone;
  logic [31:0]      opExt;
  logic             isSw, isBnez, isMemOp, isTwoReg, illegalOp, memTimeout, retire;

  // Zero-extended view so opcodes above 7 never alias onto legal ones.
  assign opExt      = 32'(opLat);
  assign isSw       = (opExt == 32'd1);
  assign isBnez     = (opExt == 32'd2);
  assign isMemOp    = (opExt <= 32'd1);
  assign isTwoReg   = (opExt == 32'd3) || (opExt == 32'd7);
  assign illegalOp  = (opExt > 32'd7);
  assign memTimeout = (memCnt == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (instr_valid) nextState = DECODE;
      DECODE:  nextState = illegalOp ? ERR : EXEC;
      EXEC: begin
        if (isMemOp)     nextState = MEM;
        else if (isBnez) nextState = IDLE;
        else             nextState = WB;
      end
      MEM: begin
        if (mem_ack)         nextState = isSw ? IDLE : WB;
        else if (memTimeout) nextState = ERR;
      end
      WB:      nextState = IDLE;
      ERR:     if (err_clr) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A store retires in the IDLE cycle after its ack, flagged by swDone.
  assign retire = (state == WB) || ((state == EXEC) && isBnez) || ((state == IDLE) && swDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opLat    <= '0;
      zfLat    <= 1'b0;
      memCnt   <= '0;
      errCause <= 2'd0;
      swDone   <= 1'b0;
      retired  <= '0;
    end else begin
      state  <= nextState;
      swDone <= (state == MEM) && mem_ack && isSw;
      if ((state == IDLE) && instr_valid) begin
        opLat <= opcode;
        zfLat <= zero_flag;
      end
      if (state == EXEC)     memCnt <= '0;
      else if (state == MEM) memCnt <= memCnt + 1'b1;
      if ((state == DECODE) && illegalOp)                  errCause <= 2'd1;
      else if ((state == MEM) && !mem_ack && memTimeout)   errCause <= 2'd2;
      else if ((state == ERR) && err_clr)                  errCause <= 2'd0;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    instr_ready = (state == IDLE);
    mem_req     = (state == MEM);
    mem_we      = (state == MEM) && isSw;
    reg_we      = (state == WB);
    two_reg_en  = ((state == DECODE) || (state == EXEC)) && isTwoReg;
    alu_op      = (state == EXEC) ? opLat[2:0] : 3'd0;
    pc_inc      = (state == WB) || ((state == EXEC) && isBnez && zfLat) || ((state == IDLE) && swDone);
    pc_load     = (state == EXEC) && isBnez && !zfLat;
    err         = (state == ERR);
    err_cause   = errCause;
    dbgState    = state;
  end

endmodule
